// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative 32-bit divider: FSM encoding,
// iteration count and the two's-complement sign helper.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = 6;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration. pr = {remainder[64:32], dividend/quotient[31:0]}.
module div_step (
    input  logic [64:0] pr_i,
    input  logic [31:0] divisor_i,
    output logic [64:0] pr_o
);

    logic [64:0] sh;
    logic [33:0] diff;

    always_comb begin
        sh   = pr_i << 1;
        // One extra bit so a negative trial difference is visible in diff[33].
        diff = {1'b0, sh[64:32]} - {2'b00, divisor_i};
        pr_o = diff[33] ? sh : {diff[32:0], sh[31:0] | 32'd1};
    end

endmodule

// File: rtl/div_ctrl.sv
// E-stage DIV/DIVU controller: 32-cycle restoring divider with stall/annul handshake.
// Define DIV_ZERO_FAST_EN to finish a zero-divisor operation one cycle after accept.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    output logic        stall_divE,
    output logic        div_ready,
    output logic [63:0] div_result
);

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [64:0]        pr_q, pr_d;
    logic [31:0]        divisor_q, divisor_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [63:0]        result_q, result_d;
    logic [64:0]        step_pr;
    logic               accept;
    logic               done_fire;
    logic               s1, s2;

    div_step u_step (
        .pr_i      (pr_q),
        .divisor_i (divisor_q),
        .pr_o      (step_pr)
    );

    assign accept    = (state_q == IDLE) && div_start && !annul;
    assign done_fire = (state_q == DONE) && !annul;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (annul) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (div_start) state_d = (FAST_ZERO && opdata2 == 32'd0) ? DONE : BUSY;
                BUSY: if (cnt_q == CNT_W'(DIV_CYCLES - 1)) state_d = DONE;
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        stall_divE = resetn && div_start && !annul && (state_q != DONE);
        div_ready  = done_fire;
        div_result = result_d;
    end

    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    always_comb begin
        cnt_d     = cnt_q;
        pr_d      = pr_q;
        divisor_d = divisor_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        s1        = div_signed & opdata1[31];
        s2        = div_signed & opdata2[31];
        if (accept) begin
            cnt_d = '0;
            // A zero divisor skips sign handling so HI returns the raw dividend.
            if (opdata2 == 32'd0) begin
                divisor_d = 32'd0;
                q_neg_d   = 1'b0;
                r_neg_d   = 1'b0;
                pr_d      = FAST_ZERO ? {1'b0, opdata1, 32'hFFFF_FFFF} : {33'd0, opdata1};
            end else begin
                divisor_d = neg_if(s2, opdata2);
                q_neg_d   = s1 ^ s2;
                r_neg_d   = s1;
                pr_d      = {33'd0, neg_if(s1, opdata1)};
            end
        end else if (state_q == BUSY) begin
            pr_d  = step_pr;
            cnt_d = cnt_q + CNT_W'(1);
        end
        result_d = done_fire ? {neg_if(r_neg_q, pr_q[63:32]), neg_if(q_neg_q, pr_q[31:0])}
                             : result_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            pr_q      <= '0;
            divisor_q <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pr_q      <= pr_d;
            divisor_q <= divisor_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed divides plus annul and mid-operation reset.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        div_start;
    logic        div_signed;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        stall_divE;
    logic        div_ready;
    logic [63:0] div_result;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          issue;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    div_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_start  (div_start),
        .div_signed (div_signed),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .stall_divE (stall_divE),
        .div_ready  (div_ready),
        .div_result (div_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (div_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", div_result, mon_e.res);
                check("latency", 64'(cyc - mon_e.issue), 64'(mon_e.lat));
            end
        end
    end

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input int lat);
        int stall_cnt;
        bit seen;
        stall_cnt = 0;
        seen      = 1'b0;
        @(posedge clk); #1;
        div_start  = 1'b1;
        div_signed = sgn;
        opdata1    = a;
        opdata2    = b;
        sb_q.push_back('{res: exp_res, lat: lat, issue: cyc});
        for (int k = 0; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (div_ready) begin
                seen = 1'b1;
                check("stall_low_at_ready", 64'(stall_divE), 64'd0);
            end else if (stall_divE) begin
                stall_cnt++;
            end
        end
        check("ready_seen", 64'(seen), 64'd1);
        check("stall_cycles", 64'(stall_cnt), 64'(lat));
        @(posedge clk); #1;
        div_start = 1'b0;
        opdata1   = 32'hDEAD_BEEF;
        opdata2   = 32'h1234_5678;
        @(negedge clk);
        check("result_hold", div_result, exp_res);
        check("ready_low_after", 64'(div_ready), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn     = 1'b0;
        div_start  = 1'b1;
        div_signed = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        annul      = 1'b0;
        @(negedge clk);
        check("rst_stall", 64'(stall_divE), 64'd0);
        check("rst_ready", 64'(div_ready), 64'd0);
        check("rst_result", div_result, 64'd0);
        @(posedge clk); #1;
        div_start = 1'b0;
        resetn    = 1'b1;

        do_div(1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},        33);
        do_div(1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        do_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'd0,        32'h8000_0000}, 33);
        do_div(1'b0, 32'd5,          32'd0,        {32'd5,        32'hFFFF_FFFF}, ZERO_LAT);
        do_div(1'b1, 32'hFFFF_FFF9,  32'd0,        {32'hFFFF_FFF9, 32'hFFFF_FFFF}, ZERO_LAT);
        do_div(1'b0, 32'hFFFF_FFFF,  32'd1,        {32'd0,        32'hFFFF_FFFF}, 33);
        do_div(1'b0, 32'hFFFF_FFF9,  32'd2,        {32'd1,        32'h7FFF_FFFC}, 33);
        do_div(1'b1, 32'd7,          32'hFFFF_FFFE, {32'd1,        32'hFFFF_FFFD}, 33);
        do_div(1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14},       33);
        do_div(1'b0, 32'd3,          32'd10,       {32'd3,        32'd0},         33);

        // Annul in cycle 10 after accept; the aborted divide must never report.
        @(posedge clk); #1;
        div_start  = 1'b1;
        div_signed = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(negedge clk);
        check("annul_stall", 64'(stall_divE), 64'd0);
        check("annul_ready", 64'(div_ready), 64'd0);
        @(posedge clk); #1;
        annul     = 1'b0;
        div_start = 1'b0;
        do_div(1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33);

        // Reset asserted in cycle 15 of an operation.
        @(posedge clk); #1;
        div_start = 1'b1;
        opdata1   = 32'd100;
        opdata2   = 32'd7;
        repeat (15) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("midrst_stall", 64'(stall_divE), 64'd0);
        check("midrst_ready", 64'(div_ready), 64'd0);
        check("midrst_result", div_result, 64'd0);
        @(posedge clk); #1;
        div_start = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        repeat (40) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
